piso_unloader: RTL
==================

Name: piso_unloader

Overview:
- Parallel-in, serial-out unloader; the read-out counterpart to the team's loadable parallel register.
- Accepts a WIDTH-bit word through a load/ready handshake, then presents it one bit per cycle on sout, qualified by sout_valid.
- Supports downstream stall and signals completion with a one-cycle done pulse.
- Sits between a parallel data register and a bit-serial consumer, for example a shift-out port or an LED/serial link driver.

Parameters:
- WIDTH, 16, word width in bits; legal range 2 or more.
- MSB_FIRST, 1, bit order: 1 shifts out d[WIDTH-1] first; 0 shifts out d[0] first.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- load  input  1  request to capture d; honoured only when ready=1.
- d  input  WIDTH  parallel word to unload.
- stall  input  1  downstream backpressure; freezes shifting while in SHIFT.
- ready  output  1  block is idle and will accept load.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout carries a valid bit this cycle.
- done  output  1  one-cycle pulse marking the cycle the final bit is presented.
- busy  output  1  word in progress; equals ~ready.

Behaviour:
- State machine has two states, IDLE and SHIFT. State, shift register shreg[WIDTH-1:0] and bit counter cnt[$clog2(WIDTH)-1:0] are registered.
- Reset, asynchronous: state=IDLE, shreg=0, cnt=0. While reset is asserted: ready=1, busy=0, sout=0, sout_valid=0, done=0.
- Reset mid-word aborts the word immediately; partial data is discarded and no done pulse is generated.
- Output decode:
  - ready = (state==IDLE); busy = ~ready.
  - sout_valid = (state==SHIFT) & ~stall.
  - sout = shreg[WIDTH-1] if MSB_FIRST, else shreg[0]; sout is forced to 0 in IDLE.
  - done = (state==SHIFT) & ~stall & (cnt==WIDTH-1).
- IDLE:
  - On load=1, at the edge: shreg<=d, cnt<=0, state<=SHIFT.
  - load=0 holds all state.
- SHIFT with stall=0:
  - The current bit is valid this cycle.
  - At the edge: if cnt==WIDTH-1, go to IDLE with shreg<=0 and cnt<=0.
  - Otherwise cnt<=cnt+1 and shreg shifts: left with 0 fill if MSB_FIRST, right with 0 fill otherwise.
- SHIFT with stall=1: shreg, cnt and state hold; sout holds its value; sout_valid=0; done=0.
- Latency: load accepted at edge N, first valid bit in cycle N+1. With no stall, bits occupy cycles N+1..N+WIDTH, done is asserted in cycle N+WIDTH, and ready=1 in cycle N+WIDTH+1.
- Throughput: one word per WIDTH+1 cycles, because load is only accepted in IDLE. A load held high across done starts the next word in the cycle after done.
- Handshake violations:
  - load asserted while busy is ignored; the word in flight is not disturbed and d is not sampled.
  - d changes after capture have no effect.
- Stall on the final bit delays done until the first unstalled cycle; done is never asserted together with stall.
- stall in IDLE has no effect.
- cnt never exceeds WIDTH-1. No wrap-around occurs inside a word.

Test Plan (WIDTH=8):
1. MSB_FIRST=1: load=1 with d=8'h1E for one cycle -> sout over the next 8 cycles = 0,0,0,1,1,1,1,0, sout_valid=1 for all 8, done only on the 8th, ready=1 on the 9th.
2. MSB_FIRST=0: same stimulus, d=8'h1E -> sout = 0,1,1,1,1,0,0,0; done on the 8th bit.
3. Stall: d=8'hF0, MSB first, stall=1 during the cycles of bit 3 and bit 8 (two cycles each) -> 12 cycles from first bit to done. sout_valid is low in the stalled cycles, the bit sequence is still 1,1,1,1,0,0,0,0, and done is asserted only after stall drops on bit 8.
4. Busy load: d=8'hAA started; at bit 4 apply load=1 with d=8'h55 -> stream remains 1,0,1,0,1,0,1,0, ready stays 0, and the 8'h55 load is ignored.
5. Back-to-back: load held high with d=8'h81, then 8'h7E presented after the first done -> 8 bits of 8'h81, one idle cycle with sout_valid=0, then 8 bits of 8'h7E, with two done pulses 9 cycles apart.
6. Reset mid-operation: assert reset asynchronously at bit 5 of d=8'hFF -> sout, sout_valid and done drop to 0 and ready goes to 1 immediately without waiting for an edge; no done pulse; the next load of 8'h01 shifts out correctly as 0,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/piso_unloader.sv
// Parallel-in, serial-out unloader: captures a WIDTH-bit word through a load/ready
// handshake and streams it one bit per cycle, honouring downstream stall.
module piso_unloader #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             stall,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             advance;

  assign last    = (cnt == CW'(WIDTH - 1));
  assign advance = (state == SHIFT) && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (load)           state_nx = SHIFT;
      SHIFT: if (!stall && last) state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  // Datapath: load in IDLE, shift with zero fill while unstalled, clear after the last bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (load) begin
        shreg <= d;
        cnt   <= '0;
      end
    end else if (advance) begin
      if (last) begin
        shreg <= '0;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        if (MSB_FIRST) shreg <= {shreg[WIDTH-2:0], 1'b0};
        else           shreg <= {1'b0, shreg[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    ready      = (state == IDLE);
    busy       = !ready;
    sout_valid = advance;
    done       = advance && last;
    sout       = 1'b0;
    if (state == SHIFT) sout = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  end

endmodule
